// File: rtl/slave_mem.sv
// slave_mem: memory-backed target for one cross_bar slave port.
// Accepts one request at a time on req, waits WAIT_CYCLES clocks,
// performs a word write or read on an internal register array and
// pulses ack for one cycle (with read data on rdata_tr after a read).
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high; clears outputs, FSM and memory
//   req       request strobe; qualifies addr/cmd/wdata
//   addr      word address; only addr[DEPTH_LOG2-1:0] is used
//   cmd       1 = write, 0 = read
//   wdata     write data, sampled at accept
//   ack       one-cycle completion pulse
//   rdata_tr  read data; holds the last read value until the next read
//   busy      high from accept until the cycle after ack
module slave_mem #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [31:0]       addr,
    input  logic              cmd,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata_tr,
    output logic              busy
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  cmd_q;
    logic [DATA_W-1:0]     wdata_q;

    logic [DATA_W-1:0]     mem [DEPTH];

    // Access selected for the current edge
    logic                  access;
    logic [DEPTH_LOG2-1:0] a_idx;
    logic                  a_cmd;
    logic [DATA_W-1:0]     a_wdata;

    logic                  accept;

    // Upper address bits are deliberately ignored (index wraps)
    logic unused_addr;
    assign unused_addr = ^addr[31:DEPTH_LOG2];

    assign accept = (state == IDLE) && req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // With zero wait states the accept edge is also the RESP entry edge,
    // so the access must use the live request inputs rather than the
    // copies latched at that same edge.
    always_comb begin
        state_nx = state;
        access   = 1'b0;
        a_idx    = idx_q;
        a_cmd    = cmd_q;
        a_wdata  = wdata_q;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nx = RESP;
                        access   = 1'b1;
                        a_idx    = addr[DEPTH_LOG2-1:0];
                        a_cmd    = cmd;
                        a_wdata  = wdata;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_nx = RESP;
                    access   = 1'b1;
                end
            end
            RESP: begin
                // req is not sampled here, so a still-high request that was
                // just acked cannot be accepted a second time.
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            idx_q    <= '0;
            cmd_q    <= 1'b0;
            wdata_q  <= '0;
            rdata_tr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i[DEPTH_LOG2-1:0]] <= '0;
            end
        end else begin
            if (accept) begin
                idx_q   <= addr[DEPTH_LOG2-1:0];
                cmd_q   <= cmd;
                wdata_q <= wdata;
                cnt     <= CNT_LOAD;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end

            if (access) begin
                if (a_cmd) begin
                    mem[a_idx] <= a_wdata;
                end else begin
                    rdata_tr <= mem[a_idx];
                end
            end
        end
    end

    // Both derive directly from the state register, so they are glitch-free
    assign ack  = (state == RESP);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_slave_mem.sv
module tb_slave_mem;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;

    // Instance with two wait states
    logic        req2   = 1'b0;
    logic [31:0] addr2  = '0;
    logic        cmd2   = 1'b0;
    logic [31:0] wdata2 = '0;
    logic        ack2;
    logic [31:0] rdata2;
    logic        busy2;

    // Instance with zero wait states
    logic        req0   = 1'b0;
    logic [31:0] addr0  = '0;
    logic        cmd0   = 1'b0;
    logic [31:0] wdata0 = '0;
    logic        ack0;
    logic [31:0] rdata0;
    logic        busy0;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] q2[$];
    logic [31:0] q0[$];

    always #5 clk = ~clk;

    slave_mem #(.DATA_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset), .req(req2), .addr(addr2), .cmd(cmd2),
        .wdata(wdata2), .ack(ack2), .rdata_tr(rdata2), .busy(busy2)
    );

    slave_mem #(.DATA_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .addr(addr0), .cmd(cmd0),
        .wdata(wdata0), .ack(ack0), .rdata_tr(rdata0), .busy(busy0)
    );

    typedef struct {
        logic        cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every ack pops the expected rdata_tr for that completion
    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset) begin
            if (ack2) begin
                if (q2.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL ack2_unexpected: got ack=1 expected ack=0 at %0t", $time);
                end else begin
                    e = q2.pop_front();
                    check("rdata2_at_ack", rdata2, e);
                end
            end
            if (ack0) begin
                if (q0.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL ack0_unexpected: got ack=1 expected ack=0 at %0t", $time);
                end else begin
                    e = q0.pop_front();
                    check("rdata0_at_ack", rdata0, e);
                end
            end
        end
    end

    // One transaction: cycle-accurate ack/busy check, inputs scrambled in
    // the ack cycle, held rdata checked in the following idle cycle.
    task automatic run_txn(input bit sel, input logic c, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd);
        int w;
        w = sel ? 0 : 2;
        @(negedge clk);
        check("busy_before_accept", 32'(sel ? busy0 : busy2), 32'd0);
        if (sel) begin
            req0 = 1'b1; cmd0 = c; addr0 = a; wdata0 = d;
            q0.push_back(exp_rd);
        end else begin
            req2 = 1'b1; cmd2 = c; addr2 = a; wdata2 = d;
            q2.push_back(exp_rd);
        end
        @(posedge clk);
        for (int i = 0; i <= w; i++) begin
            @(negedge clk);
            check("busy_in_txn", 32'(sel ? busy0 : busy2), 32'd1);
            check("ack_timing", 32'(sel ? ack0 : ack2), 32'(i == w));
        end
        if (sel) begin
            req0 = 1'b0; cmd0 = 1'($urandom); addr0 = $urandom; wdata0 = $urandom;
        end else begin
            req2 = 1'b0; cmd2 = 1'($urandom); addr2 = $urandom; wdata2 = $urandom;
        end
        @(negedge clk);
        check("ack_after", 32'(sel ? ack0 : ack2), 32'd0);
        check("busy_after", 32'(sel ? busy0 : busy2), 32'd0);
        check("rdata_held", sel ? rdata0 : rdata2, exp_rd);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'hA000_1000, 32'h1111_1111, 32'h0000_0000};
        vecs[1] = '{1'b0, 32'h2000_1000, 32'h0000_0000, 32'h1111_1111};
        vecs[2] = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1111_1111};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 32'h0000_0042, 32'h1234_5678, 32'hDEAD_BEEF};
        vecs[5] = '{1'b0, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{1'b0, 32'hFFFF_FF42, 32'h0000_0000, 32'h1234_5678};
        vecs[7] = '{1'b1, 32'h0000_0007, 32'hCAFE_F00D, 32'h1234_5678};
        vecs[8] = '{1'b0, 32'h0000_0107, 32'h0000_0000, 32'hCAFE_F00D};

        #1 reset = 1'b1;
        #1;
        check("reset_ack2", 32'(ack2), 32'd0);
        check("reset_busy2", 32'(busy2), 32'd0);
        check("reset_rdata2", rdata2, 32'd0);
        check("reset_ack0", 32'(ack0), 32'd0);
        check("reset_busy0", 32'(busy0), 32'd0);
        check("reset_rdata0", rdata0, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Table-driven transactions on the two-wait-state instance
        foreach (vecs[k]) begin
            run_txn(1'b0, vecs[k].cmd, vecs[k].addr, vecs[k].wdata, vecs[k].exp_rd);
        end

        // req held high: one ack per 4-cycle period, no re-accept at ack edge
        @(negedge clk);
        check("held_busy_start", 32'(busy2), 32'd0);
        req2 = 1'b1; cmd2 = 1'b1; addr2 = 32'h0000_0010; wdata2 = 32'h5A5A_0010;
        repeat (3) q2.push_back(32'hCAFE_F00D);
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            check("held_ack", 32'(ack2), 32'(n % 4 == 3));
            check("held_busy", 32'(busy2), 32'(n % 4 != 0));
        end
        req2 = 1'b0;
        @(negedge clk);
        check("held_end_ack", 32'(ack2), 32'd0);
        check("held_end_busy", 32'(busy2), 32'd0);
        run_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h5A5A_0010);

        // Reset during WAIT of a write: dropped, memory cleared
        @(negedge clk);
        req2 = 1'b1; cmd2 = 1'b1; addr2 = 32'h0000_0005; wdata2 = 32'h2222_2222;
        @(posedge clk);
        @(negedge clk);
        check("wait_busy_pre_reset", 32'(busy2), 32'd1);
        reset = 1'b1;
        #1;
        check("midreset_ack", 32'(ack2), 32'd0);
        check("midreset_busy", 32'(busy2), 32'd0);
        check("midreset_rdata", rdata2, 32'd0);
        req2 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("no_ack_after_reset", 32'(ack2), 32'd0);
        run_txn(1'b0, 1'b0, 32'h0000_0005, 32'h0, 32'h0000_0000);
        run_txn(1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_0000);

        // Zero-wait-state instance
        run_txn(1'b1, 1'b1, 32'h0000_0003, 32'h0000_0007, 32'h0000_0000);
        run_txn(1'b1, 1'b0, 32'h0000_0003, 32'h0,         32'h0000_0007);
        run_txn(1'b1, 1'b0, 32'h0000_0103, 32'h0,         32'h0000_0007);
        run_txn(1'b1, 1'b1, 32'h0000_0003, 32'h0000_0009, 32'h0000_0007);
        run_txn(1'b1, 1'b0, 32'hFFFF_FF03, 32'h0,         32'h0000_0009);

        repeat (2) @(negedge clk);
        check("q2_drained", 32'(q2.size()), 32'd0);
        check("q0_drained", 32'(q0.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
